// File: rtl/sd_bd_pkg.sv
// Shared constants and width helpers for the SD descriptor queue.
// A descriptor is 64 bits: source buffer address, then SD block address.
package sd_bd_pkg;

    localparam int unsigned DESC_BITS = 64;
    localparam int unsigned DATA_W_16 = 16;
    localparam int unsigned DATA_W_32 = 32;

    // Events that move a descriptor slot between the free, reserved,
    // ready and in-flight pools within one clock.
    typedef struct packed {
        logic reserve;
        logic commit;
        logic readout;
        logic rls;
    } bd_evt_t;

    function automatic bit data_w_legal(input int unsigned dw);
        return (dw == DATA_W_16) || (dw == DATA_W_32);
    endfunction

    function automatic bit bd_num_legal(input int unsigned n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

    function automatic int unsigned wpd_of(input int unsigned dw);
        return DESC_BITS / dw;
    endfunction

    function automatic int unsigned ptr_w(input int unsigned bd_num, input int unsigned dw);
        return $clog2(bd_num * wpd_of(dw));
    endfunction

    function automatic int unsigned wcnt_w(input int unsigned dw);
        return $clog2(wpd_of(dw));
    endfunction

    function automatic int unsigned cnt_w(input int unsigned bd_num);
        return $clog2(bd_num + 1);
    endfunction

endpackage

// File: rtl/sd_bd_queue_if.sv
// Host/controller side bus of the SD descriptor queue.
// master: host and SD controller; slave: the queue itself.
interface sd_bd_queue_if
    import sd_bd_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned BD_NUM = 8
);

    localparam int unsigned CNT_W = cnt_w(BD_NUM);

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              wr_rej;
    logic [CNT_W-1:0]  free_bd;
    logic              bd_valid;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_ack;
    logic              a_cmp;

    modport master (
        output wr_en, wr_data, rd_en, a_cmp,
        input  wr_rej, free_bd, bd_valid, rd_data, rd_ack
    );

    modport slave (
        input  wr_en, wr_data, rd_en, a_cmp,
        output wr_rej, free_bd, bd_valid, rd_data, rd_ack
    );

endinterface

// File: rtl/sd_bd_ram.sv
// Simple dual-port descriptor RAM: one write port, one synchronous
// registered read port. The read register clears on rst or clr; the
// array itself is never cleared.
module sd_bd_ram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port: data appears the cycle after re.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (clr) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sd_bd_queue.sv
// SD block descriptor queue. The host writes descriptors word by word,
// the SD controller reads them out, and each a_cmp rising edge returns
// one in-flight slot to the free pool.
// Optional feature: define SD_BD_FLUSH_EN to add a synchronous flush input.
module sd_bd_queue
    import sd_bd_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned BD_NUM = 8
) (
    input logic          clk,
    input logic          rst,
`ifdef SD_BD_FLUSH_EN
    input logic          flush,
`endif
    sd_bd_queue_if.slave bus
);

    localparam int unsigned WPD   = wpd_of(DATA_W);
    localparam int unsigned DEPTH = BD_NUM * WPD;
    localparam int unsigned PTR_W = ptr_w(BD_NUM, DATA_W);
    localparam int unsigned WC_W  = wcnt_w(DATA_W);
    localparam int unsigned CNT_W = cnt_w(BD_NUM);

    if (!data_w_legal(DATA_W)) begin : g_bad_data_w
        $error("sd_bd_queue: DATA_W must be 16 or 32");
    end
    if (!bd_num_legal(BD_NUM)) begin : g_bad_bd_num
        $error("sd_bd_queue: BD_NUM must be a power of 2 and at least 2");
    end

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [WC_W-1:0]  wcnt;
    logic [WC_W-1:0]  rcnt;
    logic [CNT_W-1:0] free_bd_q;
    logic [CNT_W-1:0] rdy_cnt;
    logic [CNT_W-1:0] ifl_cnt;
    logic             a_cmp_q;
    logic             wr_rej_q;
    logic             bd_valid_q;
    logic             rd_ack_q;

    logic             wr_acc;
    logic             rd_acc;
    bd_evt_t          evt;
    logic [CNT_W-1:0] free_nxt;
    logic [CNT_W-1:0] rdy_nxt;
    logic [CNT_W-1:0] ifl_nxt;
    logic             ram_clr;
    logic [DATA_W-1:0] ram_rdata;

    // Accept decisions and pool movements; all counters apply their
    // increments and decrements together so no simultaneous event is lost.
    always_comb begin
        wr_acc = bus.wr_en && ((free_bd_q != '0) || (wcnt != '0));
        rd_acc = bus.rd_en && ((rdy_cnt != '0) || (rcnt != '0));
`ifdef SD_BD_FLUSH_EN
        if (flush) begin
            wr_acc = 1'b0;
            rd_acc = 1'b0;
        end
`endif
        evt         = '0;
        evt.reserve = wr_acc && (wcnt == '0);
        evt.commit  = wr_acc && (wcnt == WC_W'(WPD - 1));
        evt.readout = rd_acc && (rcnt == WC_W'(WPD - 1));
        evt.rls     = bus.a_cmp && !a_cmp_q && (ifl_cnt != '0);
        free_nxt    = free_bd_q - CNT_W'(evt.reserve) + CNT_W'(evt.rls);
        rdy_nxt     = rdy_cnt + CNT_W'(evt.commit) - CNT_W'(evt.readout);
        ifl_nxt     = ifl_cnt + CNT_W'(evt.readout) - CNT_W'(evt.rls);
    end

`ifdef SD_BD_FLUSH_EN
    assign ram_clr = flush;
`else
    assign ram_clr = 1'b0;
`endif

    // Pointers, word counters, slot pools and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            wcnt       <= '0;
            rcnt       <= '0;
            free_bd_q  <= CNT_W'(BD_NUM);
            rdy_cnt    <= '0;
            ifl_cnt    <= '0;
            a_cmp_q    <= 1'b0;
            wr_rej_q   <= 1'b0;
            bd_valid_q <= 1'b0;
            rd_ack_q   <= 1'b0;
        end
`ifdef SD_BD_FLUSH_EN
        else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            wcnt       <= '0;
            rcnt       <= '0;
            free_bd_q  <= CNT_W'(BD_NUM);
            rdy_cnt    <= '0;
            ifl_cnt    <= '0;
            a_cmp_q    <= 1'b0;
            wr_rej_q   <= 1'b0;
            bd_valid_q <= 1'b0;
            rd_ack_q   <= 1'b0;
        end
`endif
        else begin
            a_cmp_q    <= bus.a_cmp;
            wr_rej_q   <= bus.wr_en && !wr_acc;
            rd_ack_q   <= rd_acc;
            free_bd_q  <= free_nxt;
            rdy_cnt    <= rdy_nxt;
            ifl_cnt    <= ifl_nxt;
            bd_valid_q <= (rdy_nxt != '0);
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                wcnt   <= wcnt + WC_W'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                rcnt   <= rcnt + WC_W'(1);
            end
        end
    end

    sd_bd_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .clr   (ram_clr),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (bus.wr_data),
        .re    (rd_acc),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    assign bus.wr_rej   = wr_rej_q;
    assign bus.free_bd  = free_bd_q;
    assign bus.bd_valid = bd_valid_q;
    assign bus.rd_ack   = rd_ack_q;
    assign bus.rd_data  = ram_rdata;

endmodule

// File: doc/sd_bd_queue.md
SD_BD_QUEUE -- requirements
Module: sd_bd_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the word width; the legal values are 16 and 32.
REQ-002 SHALL have parameter BD_NUM, default 8, meaning the descriptor slot count; it SHALL be a power of 2 and at least 2.
REQ-003 SHALL derive WPD = 64/DATA_W as the words per descriptor: the source buffer address followed by the SD block address.
REQ-004 SHALL have port clk, input, 1 bit: clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port wr_en, input, 1 bit: host descriptor word write strobe.
REQ-007 SHALL have port wr_data, input, DATA_W bits: host descriptor word.
REQ-008 SHALL have port wr_rej, output, 1 bit: one-cycle pulse when a write is refused.
REQ-009 SHALL have port free_bd, output, $clog2(BD_NUM+1) bits: number of unreserved descriptor slots.
REQ-010 SHALL have port bd_valid, output, 1 bit: at least one complete, unread descriptor is present.
REQ-011 SHALL have port rd_en, input, 1 bit: controller word read strobe.
REQ-012 SHALL have port rd_data, output, DATA_W bits: registered read word.
REQ-013 SHALL have port rd_ack, output, 1 bit: rd_data is valid this cycle.
REQ-014 SHALL have port a_cmp, input, 1 bit: transfer-complete level; only its rising edge is significant.

Function
REQ-015 SHALL accept a write when wr_en=1 and either (free_bd>0 and wcnt=0) or wcnt!=0; the partial descriptor's slot is already reserved.
REQ-016 SHALL, for a refused write, leave the memory and pointers untouched and assert wr_rej on the next cycle.
REQ-017 SHALL store an accepted word at wr_ptr, increment wr_ptr modulo BD_NUM*WPD, and increment wcnt modulo WPD.
REQ-018 SHALL, on the edge accepting word 0 of a descriptor, decrement free_bd.
REQ-019 SHALL, on the edge accepting word WPD-1, increment rdy_cnt, so that bd_valid rises the following cycle.
REQ-020 SHALL accept a read when rd_en=1 and either rdy_cnt>0 or rcnt!=0; otherwise rd_en is ignored and rd_ack stays 0.
REQ-021 SHALL give an accepted read at edge N rd_data=mem[rd_ptr] with rd_ack=1 in cycle N+1, then advance rd_ptr and rcnt with modulo wrap.
REQ-022 SHALL, on the read of word WPD-1, decrement rdy_cnt and increment the in-flight count ifl_cnt.
REQ-023 SHALL, on a rising a_cmp edge with ifl_cnt>0, decrement ifl_cnt and increment free_bd; with ifl_cnt=0 the edge SHALL be ignored.
REQ-024 SHALL apply simultaneous reserve, release, commit and read-out as independent net updates, with no priority loss: for example, a reserve plus a release leaves free_bd unchanged.
REQ-025 SHALL hold the invariant free_bd + reserved + rdy_cnt + ifl_cnt = BD_NUM at all times; free_bd never exceeds BD_NUM and never goes below 0.
REQ-026 SHALL read a word written on the same edge only after the commit, since bd_valid is registered; there is no read-during-write bypass.

Reset
REQ-027 SHALL, while rst=1, force free_bd=BD_NUM; wr_rej, bd_valid, rd_ack=0; rd_data=0; all pointers, wcnt, rcnt, rdy_cnt, ifl_cnt=0; and the a_cmp edge register=0.
REQ-028 SHALL discard a partial descriptor when reset occurs mid-operation; memory contents are not cleared.

Configuration
REQ-029 SHALL, when macro SD_BD_FLUSH_EN is defined, add an input port flush (1 bit).
REQ-030 SHALL make flush=1 synchronously clear all state to reset values on the next edge; flush overrides every simultaneous write, read or a_cmp event.
REQ-031 SHALL, without SD_BD_FLUSH_EN, have no flush port and no flush logic.

Structure
REQ-032 SHALL place DESC_BITS=64, the legal DATA_W values, and the pointer and count width functions in package sd_bd_pkg.
REQ-033 SHALL instantiate one sub-module, sd_bd_ram: a simple dual-port RAM with BD_NUM*WPD words, one write port, and a synchronous registered read port.

Verification
REQ-034 SHALL cover: with DATA_W=32 and BD_NUM=8, write 0x1000 then 0x0040 -> free_bd 8->7 after the first word, bd_valid=1 after the second; 2 reads -> rd_ack on the 2 cycles following rd_en, rd_data=0x1000 then 0x0040.
REQ-035 SHALL cover: with DATA_W=16, write 8 descriptors of 4 words, then a ninth write -> free_bd=0, wr_rej pulses once, memory unchanged.
REQ-036 SHALL cover: free_bd=3 with one in-flight descriptor, and a write of word 0 in the same cycle as an a_cmp rising edge -> free_bd stays 3.
REQ-037 SHALL cover: a_cmp held high for 5 cycles with ifl_cnt=1 -> free_bd increments exactly once; a second rising edge with ifl_cnt=0 -> no change.
REQ-038 SHALL cover: 20 descriptors streamed through BD_NUM=4 -> pointers wrap, data is read back in order, and the invariant holds every cycle.
REQ-039 SHALL cover, with SD_BD_FLUSH_EN defined: flush asserted mid-descriptor together with rd_en -> next cycle free_bd=BD_NUM, bd_valid=0, rd_ack=0.
